// File: rtl/cca_ed_detect.sv
// Energy-detect CCA: hysteresis thresholds, arming run-length and release hold timer on the averaged power stream.
// Optional busy-period peak capture is enabled with the CCA_ED_PEAK_EN macro.
module cca_ed_detect #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int ARM_WIDTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] avg_in,
    input  logic                         avg_in_valid,
    input  logic signed [DATA_WIDTH-1:0] th_assert,
    input  logic signed [DATA_WIDTH-1:0] th_deassert,
    input  logic        [ARM_WIDTH-1:0]  arm_len,
    input  logic        [CNT_WIDTH-1:0]  hold_len,
    output logic                         busy,
    output logic                         busy_rise,
    output logic                         busy_fall,
    output logic        [CNT_WIDTH-1:0]  busy_dur,
    output logic                         busy_dur_valid
`ifdef CCA_ED_PEAK_EN
    ,
    output logic signed [DATA_WIDTH-1:0] busy_peak
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_BUSY = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [ARM_WIDTH-1:0] ARM_ZERO = {ARM_WIDTH{1'b0}};
    localparam logic [ARM_WIDTH-1:0] ARM_ONE  = ARM_WIDTH'(1'b1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_WIDTH'(1'b1);
        end
    endfunction

    state_t                  state_q, state_d;
    logic [ARM_WIDTH-1:0]    arm_cnt_q, arm_cnt_d;
    logic [CNT_WIDTH-1:0]    hold_cnt_q, hold_cnt_d;
    logic [CNT_WIDTH-1:0]    dur_cnt_q, dur_cnt_d;
    logic                    busy_q, busy_d;
    logic                    busy_rise_q, busy_rise_d;
    logic                    busy_fall_q, busy_fall_d;
    logic [CNT_WIDTH-1:0]    busy_dur_q, busy_dur_d;
    logic                    busy_dur_valid_q, busy_dur_valid_d;

    logic signed [DATA_WIDTH-1:0] th_rel_s;
    logic [ARM_WIDTH-1:0]         arm_eff_s;
    logic [ARM_WIDTH:0]           arm_next_s;
    logic [CNT_WIDTH:0]           hold_next_s;
    logic                         ge_assert_s, ge_rel_s, arm_done_s, hold_expire_s;
    logic                         release_s;

    // Threshold clamping and counter compares; widened sums avoid wrap when config changes on the fly.
    always_comb begin
        th_rel_s      = (th_deassert < th_assert) ? th_deassert : th_assert;
        arm_eff_s     = (arm_len == ARM_ZERO) ? ARM_ONE : arm_len;
        ge_assert_s   = (avg_in >= th_assert);
        ge_rel_s      = (avg_in >= th_rel_s);
        arm_next_s    = {1'b0, arm_cnt_q} + (ARM_WIDTH+1)'(1'b1);
        arm_done_s    = (arm_next_s >= {1'b0, arm_eff_s});
        hold_next_s   = {1'b0, hold_cnt_q} + (CNT_WIDTH+1)'(1'b1);
        hold_expire_s = (hold_next_s >= {1'b0, hold_len});
    end

    // Next-state logic for the arm / busy / hold sequence.
    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        hold_cnt_d = hold_cnt_q;
        release_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arm_cnt_d  = ARM_ZERO;
                hold_cnt_d = CNT_ZERO;
                if (avg_in_valid && ge_assert_s) begin
                    if (arm_eff_s == ARM_ONE) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d   = ST_ARM;
                        arm_cnt_d = ARM_ONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (avg_in_valid && ge_assert_s) begin
                    if (arm_done_s) begin
                        state_d   = ST_BUSY;
                        arm_cnt_d = ARM_ZERO;
                    end else begin
                        arm_cnt_d = arm_next_s[ARM_WIDTH-1:0];
                    end
                end else if (avg_in_valid) begin
                    state_d   = ST_IDLE;
                    arm_cnt_d = ARM_ZERO;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_BUSY: begin
                hold_cnt_d = CNT_ZERO;
                if (avg_in_valid && !ge_rel_s) begin
                    if (hold_len == CNT_ZERO) begin
                        state_d   = ST_IDLE;
                        release_s = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_HOLD: begin
                // A recovering sample wins over timer expiry in the same cycle.
                if (avg_in_valid && ge_rel_s) begin
                    state_d    = ST_BUSY;
                    hold_cnt_d = CNT_ZERO;
                end else if (hold_expire_s) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = CNT_ZERO;
                    release_s  = 1'b1;
                end else begin
                    hold_cnt_d = hold_next_s[CNT_WIDTH-1:0];
                end
            end
            default: begin
                state_d    = ST_IDLE;
                arm_cnt_d  = ARM_ZERO;
                hold_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // Busy flag, edge pulses and busy-period duration.
    always_comb begin
        busy_d           = (state_d == ST_BUSY) || (state_d == ST_HOLD);
        busy_rise_d      = busy_d && !busy_q;
        busy_fall_d      = release_s;
        busy_dur_valid_d = release_s;
        if (release_s) begin
            dur_cnt_d  = CNT_ZERO;
            busy_dur_d = sat_inc(dur_cnt_q);
        end else if (busy_q) begin
            dur_cnt_d  = sat_inc(dur_cnt_q);
            busy_dur_d = busy_dur_q;
        end else begin
            dur_cnt_d  = CNT_ZERO;
            busy_dur_d = busy_dur_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            arm_cnt_q        <= ARM_ZERO;
            hold_cnt_q       <= CNT_ZERO;
            dur_cnt_q        <= CNT_ZERO;
            busy_q           <= 1'b0;
            busy_rise_q      <= 1'b0;
            busy_fall_q      <= 1'b0;
            busy_dur_q       <= CNT_ZERO;
            busy_dur_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            arm_cnt_q        <= arm_cnt_d;
            hold_cnt_q       <= hold_cnt_d;
            dur_cnt_q        <= dur_cnt_d;
            busy_q           <= busy_d;
            busy_rise_q      <= busy_rise_d;
            busy_fall_q      <= busy_fall_d;
            busy_dur_q       <= busy_dur_d;
            busy_dur_valid_q <= busy_dur_valid_d;
        end
    end

    assign busy           = busy_q;
    assign busy_rise      = busy_rise_q;
    assign busy_fall      = busy_fall_q;
    assign busy_dur       = busy_dur_q;
    assign busy_dur_valid = busy_dur_valid_q;

`ifdef CCA_ED_PEAK_EN
    localparam logic signed [DATA_WIDTH-1:0] PEAK_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0] peak_run_q, peak_run_d;
    logic signed [DATA_WIDTH-1:0] busy_peak_q, busy_peak_d;
    logic signed [DATA_WIDTH-1:0] sample_max_s;

    // Running maximum restarts on the first arming sample so arming samples are included.
    always_comb begin
        sample_max_s = (avg_in > peak_run_q) ? avg_in : peak_run_q;
        if (state_q == ST_IDLE) begin
            peak_run_d = (avg_in_valid && ge_assert_s) ? avg_in : PEAK_MIN;
        end else if (avg_in_valid) begin
            peak_run_d = sample_max_s;
        end else begin
            peak_run_d = peak_run_q;
        end
        if (release_s) begin
            busy_peak_d = avg_in_valid ? sample_max_s : peak_run_q;
        end else begin
            busy_peak_d = busy_peak_q;
        end
    end

    // Peak tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_run_q  <= PEAK_MIN;
            busy_peak_q <= PEAK_MIN;
        end else begin
            peak_run_q  <= peak_run_d;
            busy_peak_q <= busy_peak_d;
        end
    end

    assign busy_peak = busy_peak_q;
`endif

endmodule

// File: tb/tb_cca_ed_detect.sv
// Directed bench for cca_ed_detect: per-step expected outputs are queued when driven and checked one clock later.
module tb_cca_ed_detect;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic signed [DW-1:0] avg_in, th_assert, th_deassert;
    logic                 avg_in_valid;
    logic [AW-1:0]        arm_len;
    logic [CW-1:0]        hold_len;
    logic                 busy, busy_rise, busy_fall, busy_dur_valid;
    logic [CW-1:0]        busy_dur;
`ifdef CCA_ED_PEAK_EN
    logic signed [DW-1:0] busy_peak;
`endif

    cca_ed_detect #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .ARM_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .avg_in         (avg_in),
        .avg_in_valid   (avg_in_valid),
        .th_assert      (th_assert),
        .th_deassert    (th_deassert),
        .arm_len        (arm_len),
        .hold_len       (hold_len),
        .busy           (busy),
        .busy_rise      (busy_rise),
        .busy_fall      (busy_fall),
        .busy_dur       (busy_dur),
        .busy_dur_valid (busy_dur_valid)
`ifdef CCA_ED_PEAK_EN
        ,
        .busy_peak      (busy_peak)
`endif
    );

    typedef struct {
        int                   id;
        logic                 b, r, f, dv;
        logic [CW-1:0]        dur;
        logic signed [DW-1:0] pk;
    } exp_t;

    exp_t                 q[$];
    int                   total = 0;
    int                   bad   = 0;
    int                   sid   = 0;
    logic [CW-1:0]        ld;
    logic signed [DW-1:0] lpk, pk_next;

    task automatic check_front();
        exp_t e;
        if (q.size() == 0) return;
        e = q.pop_front();
        total++;
        assert (busy === e.b) else begin
            bad++; $error("FAIL step%0d busy got %0b want %0b", e.id, busy, e.b);
        end
        total++;
        assert (busy_rise === e.r) else begin
            bad++; $error("FAIL step%0d busy_rise got %0b want %0b", e.id, busy_rise, e.r);
        end
        total++;
        assert (busy_fall === e.f) else begin
            bad++; $error("FAIL step%0d busy_fall got %0b want %0b", e.id, busy_fall, e.f);
        end
        total++;
        assert (busy_dur_valid === e.dv) else begin
            bad++; $error("FAIL step%0d busy_dur_valid got %0b want %0b", e.id, busy_dur_valid, e.dv);
        end
        total++;
        assert (busy_dur === e.dur) else begin
            bad++; $error("FAIL step%0d busy_dur got %0d want %0d", e.id, busy_dur, e.dur);
        end
`ifdef CCA_ED_PEAK_EN
        total++;
        assert (busy_peak === e.pk) else begin
            bad++; $error("FAIL step%0d busy_peak got %0d want %0d", e.id, busy_peak, e.pk);
        end
`endif
    endtask

    // Drive one clock of stimulus, queue what the outputs must be after the edge, then check at the next negedge.
    task automatic step(input logic v, input int x, input logic eb, input logic er,
                        input logic ef, input logic edv, input int nd);
        avg_in_valid = v;
        avg_in       = DW'(x);
        sid++;
        if (rst) begin
            ld  = '0;
            lpk = -16'sd32768;
        end else if (edv) begin
            ld  = CW'(nd);
            lpk = pk_next;
        end
        q.push_back('{sid, eb, er, ef, edv, ld, lpk});
        @(negedge clk);
        check_front();
    endtask

    initial begin
        rst = 1'b1; avg_in_valid = 1'b0; avg_in = '0;
        th_assert = 16'sd100; th_deassert = 16'sd80; arm_len = 4'd3; hold_len = 4'd4;
        ld = '0; lpk = -16'sd32768; pk_next = -16'sd32768;
        @(negedge clk);
        step(0, 0,   0, 0, 0, 0, 0);
        step(0, 0,   0, 0, 0, 0, 0);
        rst = 1'b0;

        // Three qualifying samples arm and raise busy.
        step(1, 120, 0, 0, 0, 0, 0);
        step(1, 120, 0, 0, 0, 0, 0);
        step(1, 120, 1, 1, 0, 0, 0);
        step(0, 0,   1, 0, 0, 0, 0);
        // Dip then recovery inside the hold window: no pulses.
        step(1, 70,  1, 0, 0, 0, 0);
        step(0, 0,   1, 0, 0, 0, 0);
        step(1, 90,  1, 0, 0, 0, 0);
        // Dip and timeout: fall on the fifth cycle after the 70.
        step(1, 70,  1, 0, 0, 0, 0);
        step(0, 0,   1, 0, 0, 0, 0);
        step(0, 0,   1, 0, 0, 0, 0);
        step(0, 0,   1, 0, 0, 0, 0);
        pk_next = 16'sd120;
        step(0, 0,   0, 0, 1, 1, 9);
        step(0, 0,   0, 0, 0, 0, 0);

        // Arming broken by a low sample; an invalid strobe does not count.
        step(1, 120, 0, 0, 0, 0, 0);
        step(1, 120, 0, 0, 0, 0, 0);
        step(1, 50,  0, 0, 0, 0, 0);
        step(1, 120, 0, 0, 0, 0, 0);
        step(0, 200, 0, 0, 0, 0, 0);
        step(1, 120, 0, 0, 0, 0, 0);
        step(1, 120, 1, 1, 0, 0, 0);

        // Release threshold clamped to th_assert, immediate release with hold_len=0.
        th_deassert = 16'sd150; hold_len = 4'd0;
        step(1, 120, 1, 0, 0, 0, 0);
        pk_next = 16'sd120;
        step(1, 99,  0, 0, 1, 1, 2);
        step(0, 0,   0, 0, 0, 0, 0);

        // arm_len=0 acts as 1; sample equal to th_assert arms; long period saturates.
        th_deassert = 16'sd80; hold_len = 4'd4; arm_len = 4'd0;
        step(1, 100, 1, 1, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(1, 70,  1, 0, 0, 0, 0);
        step(0, 0,   1, 0, 0, 0, 0);
        step(0, 0,   1, 0, 0, 0, 0);
        step(0, 0,   1, 0, 0, 0, 0);
        pk_next = 16'sd100;
        step(0, 0,   0, 0, 1, 1, 15);
        step(0, 0,   0, 0, 0, 0, 0);

        // Reset in the middle of a busy period: no fall, duration cleared.
        step(1, 120, 1, 1, 0, 0, 0);
        step(0, 0,   1, 0, 0, 0, 0);
        rst = 1'b1;
        step(0, 0,   0, 0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0,   0, 0, 0, 0, 0);
        step(0, 0,   0, 0, 0, 0, 0);

        // Negative thresholds exercise the signed compare; sample equal to th_rel stays busy.
        th_assert = -16'sd20; th_deassert = -16'sd40; hold_len = 4'd0;
        step(1, 5,   1, 1, 0, 0, 0);
        step(1, -40, 1, 0, 0, 0, 0);
        pk_next = 16'sd5;
        step(1, -50, 0, 0, 1, 1, 2);
        step(0, 0,   0, 0, 0, 0, 0);

`ifdef CCA_ED_PEAK_EN
        th_assert = 16'sd100; th_deassert = 16'sd80; arm_len = 4'd3; hold_len = 4'd0;
        step(1, 110, 0, 0, 0, 0, 0);
        step(1, 130, 0, 0, 0, 0, 0);
        step(1, 105, 1, 1, 0, 0, 0);
        step(1, 200, 1, 0, 0, 0, 0);
        pk_next = 16'sd200;
        step(1, 50,  0, 0, 1, 1, 2);
        step(0, 0,   0, 0, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cca_ed_detect.md
Name: cca_ed_detect

Overview:
- Energy-detect clear-channel-assessment stage. Sits directly downstream of the moving-average block.
- Consumes the averaged signed power/RSSI stream and applies hysteresis thresholds, an arming run-length and a release hold timer.
- Produces a registered channel-busy flag plus edge pulses and the measured length of each busy period. The xpu CSMA/backoff logic reads these outputs.

Parameters:
- DATA_WIDTH, 16, width of averaged input sample and thresholds (signed)
- CNT_WIDTH, 16, width of hold timer and busy-duration counter
- ARM_WIDTH, 4, width of arming run-length input

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- avg_in  in  DATA_WIDTH  signed averaged sample
- avg_in_valid  in  1  qualifies avg_in; one-cycle strobe, may be back-to-back or sparse
- th_assert  in  DATA_WIDTH  signed busy-assert threshold
- th_deassert  in  DATA_WIDTH  signed busy-release threshold
- arm_len  in  ARM_WIDTH  consecutive valid samples >= th_assert needed to go busy
- hold_len  in  CNT_WIDTH  clk cycles below threshold before release
- busy  out  1  channel busy flag
- busy_rise  out  1  one-cycle pulse when busy goes 0->1
- busy_fall  out  1  one-cycle pulse when busy goes 1->0
- busy_dur  out  CNT_WIDTH  length in clk cycles of the last completed busy period
- busy_dur_valid  out  1  one-cycle pulse, asserted with busy_fall

Behaviour:
- Reset: state IDLE; busy, busy_rise, busy_fall, busy_dur_valid = 0; busy_dur = 0; all counters 0. A reset mid-period aborts the period with no fall pulse and no duration update.
- Config inputs are live, not latched. Each valid sample is compared against the values present in that cycle.
- Signed compare at DATA_WIDTH.
- Effective release threshold th_rel = min(th_deassert, th_assert). This prevents an inverted hysteresis window.
- Effective arm length = max(arm_len, 1).
- Samples are evaluated only on cycles with avg_in_valid=1. Non-valid cycles never change the arm count.
- FSM states and transitions:
  - IDLE, valid sample >= th_assert: arm_cnt=1. If effective arm length is 1, go BUSY; otherwise go ARM.
  - IDLE, valid sample < th_assert: stay IDLE.
  - ARM, valid sample >= th_assert: arm_cnt+1. On reaching the effective arm length, go BUSY.
  - ARM, valid sample < th_assert: arm_cnt=0, go IDLE.
  - BUSY, valid sample < th_rel: hold_cnt=0. If hold_len=0, go IDLE (release); otherwise go HOLD.
  - BUSY, any other case: stay BUSY.
  - HOLD: hold_cnt increments every clk cycle, valid or not.
  - HOLD, valid sample >= th_rel: go BUSY with hold_cnt cleared. This has priority over timer expiry in the same cycle, and produces no pulses.
  - HOLD, hold_cnt reaches hold_len-1: go IDLE (release).
- busy is registered. It is 1 in BUSY and HOLD and goes high on the clk edge after the valid sample that completes arming (latency 1).
- busy_rise is high for exactly the first cycle busy=1. busy_fall is high for exactly the first cycle busy=0 after a release.
- Duration counter:
  - Counts every clk cycle with busy=1; the first busy cycle counts as 1.
  - Saturates at 2^CNT_WIDTH-1, with no wrap.
  - On release, busy_dur is loaded with the final count and busy_dur_valid pulses together with busy_fall. The counter then clears.
- Release and a new arming sample in the same cycle: the release completes first. That sample is evaluated in IDLE on the next valid strobe only; it is not double-counted.
- Raising hold_len during HOLD extends the hold. Lowering it below the current hold_cnt releases on the next cycle.

Optional Feature:
- Macro: CCA_ED_PEAK_EN.
- When defined, add output busy_peak [DATA_WIDTH-1:0] (signed).
  - Holds the maximum valid avg_in seen during the last completed busy period, including the arming samples.
  - Updated on the same cycle as busy_dur_valid.
  - Reset value is the most negative DATA_WIDTH value.
- When undefined, the port and its register do not exist, and all other behaviour is identical.

Test Plan:
- Setup: th_assert=100, th_deassert=80, arm_len=3, hold_len=4. Samples 120,120,120 on consecutive cycles -> busy=1 and busy_rise pulse on the cycle after the third sample.
- Samples 120,120,50,120 -> arming resets at 50; busy stays 0 until two more >=100 samples follow the final 120.
- While busy, send 70, then 90 two cycles later -> returns to BUSY with no fall pulse. Then send 70 with no further valid samples -> busy_fall and busy_dur_valid on the 5th cycle after the 70.
- hold_len=0, th_deassert=150 (clamped to 100), busy, send 99 -> busy=0 with fall pulse on the next cycle; busy_dur equals the cycles counted.
- CNT_WIDTH=4, busy held for 40 cycles -> busy_dur=15 (saturated). Assert rst mid-BUSY -> all outputs 0 next cycle, no busy_fall.
- With CCA_ED_PEAK_EN: arming samples 110,130,105, then 200, then release -> busy_peak=200 alongside busy_dur_valid.
